// File: rtl/mem_port_responder_pkg.sv
// mem_port_types: shared types for the memory port responder.
//   state_e : responder FSM states (IDLE, SERVE_A, SERVE_B, RESP)
//   port_e  : which initiator port a transaction belongs to
//   op_e    : backing operation kind
package mem_port_types;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_A = 2'd1,
      SERVE_B = 2'd2,
      RESP    = 2'd3
   } state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

endpackage

// File: rtl/mem_port_ibuf.sv
// mem_port_ibuf: one-entry instruction buffer (valid, word address, data).
// Only instantiated when MEM_PORT_IBUF_EN is defined.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valid)
//   fill            load entry with fill_address/fill_data (port-A completion)
//   fill_address    word-aligned address of the completed read
//   fill_data       data returned by the backing memory
//   inval           port-B write entering service this cycle
//   inval_address   word-aligned address of that write
//   lookup_address  word-aligned port-A request address
//   hit             entry valid and lookup_address matches
//   hit_data        buffered data
module mem_port_ibuf
   import mem_port_types::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill,
   input  logic [ADDR_W-1:0] fill_address,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              inval,
   input  logic [ADDR_W-1:0] inval_address,
   input  logic [ADDR_W-1:0] lookup_address,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);

   logic              valid_r;
   logic [ADDR_W-1:0] tag_r;
   logic [DATA_W-1:0] data_r;

   // Entry update: fill on port-A completion, drop on a write to the same word.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         tag_r   <= {ADDR_W{1'b0}};
         data_r  <= {DATA_W{1'b0}};
      end else if (fill) begin
         valid_r <= 1'b1;
         tag_r   <= fill_address;
         data_r  <= fill_data;
      end else if (inval && (inval_address == tag_r)) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign hit      = valid_r & (lookup_address == tag_r);
   assign hit_data = data_r;

endmodule

// File: rtl/mem_port_responder.sv
// mem_port_responder: arbitrates instruction port A (read-only) and data
// port B (read/write, byte mask) onto one backing memory interface with a
// single outstanding transaction. Completion is a one-cycle resp pulse.
// Optional feature macro: MEM_PORT_IBUF_EN (one-entry instruction buffer).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   read_a, address_a                 port A read request (level) and address
//   rdata_a, resp_a                   port A data and completion pulse
//   read_b, write, wmask, address_b,  port B request, byte enables, address,
//   wdata                             write data
//   rdata_b, resp_b                   port B load data and completion pulse
//   mem_read, mem_write, mem_address, backing strobes, word-aligned address,
//   mem_wdata, mem_byte_enable        write data and byte enables
//   mem_rdata, mem_resp               backing read data and completion
module mem_port_responder
   import mem_port_types::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int B_PRIORITY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                read_a,
   input  logic [ADDR_W-1:0]   address_a,
   output logic [DATA_W-1:0]   rdata_a,
   output logic                resp_a,
   input  logic                read_b,
   input  logic                write,
   input  logic [DATA_W/8-1:0] wmask,
   input  logic [ADDR_W-1:0]   address_b,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata_b,
   output logic                resp_b,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_byte_enable,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_resp
);

   localparam int                BE_W         = DATA_W / 8;
   localparam logic [ADDR_W-1:0] ALIGN_MASK_C = ADDR_W'(BE_W - 1);

   state_e              state_r;
   port_e               port_r;
   op_e                 op_r;
   logic                resp_a_r;
   logic                resp_b_r;
   logic                mem_read_r;
   logic                mem_write_r;
   logic [ADDR_W-1:0]   mem_address_r;
   logic [DATA_W-1:0]   mem_wdata_r;
   logic [BE_W-1:0]     mem_byte_enable_r;
   logic [DATA_W-1:0]   rdata_a_r;
   logic [DATA_W-1:0]   rdata_b_r;

   logic                b_req_s;
   logic                sel_a_s;
   logic                sel_b_s;
   logic [ADDR_W-1:0]   a_word_s;
   logic [ADDR_W-1:0]   b_word_s;
   logic                ibuf_hit_s;
   logic [DATA_W-1:0]   ibuf_data_s;

   assign a_word_s = address_a & ~ALIGN_MASK_C;
   assign b_word_s = address_b & ~ALIGN_MASK_C;

   // Arbitration between the two ports; a write with read_b also high counts once as port B.
   always_comb begin
      b_req_s = read_b | write;
      if (B_PRIORITY != 0) begin
         sel_b_s = b_req_s;
      end else begin
         sel_b_s = b_req_s & ~read_a;
      end
      sel_a_s = read_a & ~sel_b_s;
   end

`ifdef MEM_PORT_IBUF_EN
   logic ibuf_fill_s;
   logic ibuf_inval_s;

   // The buffer sees the SERVE_B entry of a write in the same cycle the FSM takes it.
   assign ibuf_fill_s  = (state_r == SERVE_A) & mem_resp;
   assign ibuf_inval_s = (state_r == IDLE) & sel_b_s & write;

   mem_port_ibuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ibuf (
      .clk            (clk),
      .rst            (rst),
      .fill           (ibuf_fill_s),
      .fill_address   (mem_address_r),
      .fill_data      (mem_rdata),
      .inval          (ibuf_inval_s),
      .inval_address  (b_word_s),
      .lookup_address (a_word_s),
      .hit            (ibuf_hit_s),
      .hit_data       (ibuf_data_s)
   );
`else
   assign ibuf_hit_s  = 1'b0;
   assign ibuf_data_s = {DATA_W{1'b0}};
`endif

   // Responder FSM; all outputs are registered and updated on state transitions.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r           <= IDLE;
         port_r            <= PORT_A;
         op_r              <= OP_READ;
         resp_a_r          <= 1'b0;
         resp_b_r          <= 1'b0;
         mem_read_r        <= 1'b0;
         mem_write_r       <= 1'b0;
         mem_address_r     <= {ADDR_W{1'b0}};
         mem_wdata_r       <= {DATA_W{1'b0}};
         mem_byte_enable_r <= {BE_W{1'b0}};
         rdata_a_r         <= {DATA_W{1'b0}};
         rdata_b_r         <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (sel_b_s) begin
                  state_r       <= SERVE_B;
                  port_r        <= PORT_B;
                  mem_address_r <= b_word_s;
                  mem_wdata_r   <= wdata;
                  if (write) begin
                     op_r              <= OP_WRITE;
                     mem_write_r       <= 1'b1;
                     mem_byte_enable_r <= wmask;
                  end else begin
                     op_r              <= OP_READ;
                     mem_read_r        <= 1'b1;
                     mem_byte_enable_r <= {BE_W{1'b1}};
                  end
               end else if (sel_a_s && ibuf_hit_s) begin
                  // Buffered instruction: complete without touching the backing memory.
                  state_r   <= RESP;
                  port_r    <= PORT_A;
                  op_r      <= OP_READ;
                  rdata_a_r <= ibuf_data_s;
                  resp_a_r  <= 1'b1;
               end else if (sel_a_s) begin
                  state_r           <= SERVE_A;
                  port_r            <= PORT_A;
                  op_r              <= OP_READ;
                  mem_read_r        <= 1'b1;
                  mem_address_r     <= a_word_s;
                  mem_byte_enable_r <= {BE_W{1'b1}};
               end else begin
                  state_r <= IDLE;
               end
            end
            SERVE_A, SERVE_B: begin
               if (mem_resp) begin
                  state_r     <= RESP;
                  mem_read_r  <= 1'b0;
                  mem_write_r <= 1'b0;
                  if (port_r == PORT_A) begin
                     resp_a_r  <= 1'b1;
                     rdata_a_r <= mem_rdata;
                  end else begin
                     resp_b_r <= 1'b1;
                     if (op_r == OP_READ) begin
                        rdata_b_r <= mem_rdata;
                     end else begin
                        rdata_b_r <= rdata_b_r;
                     end
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            RESP: begin
               // Requests are not sampled here, giving the initiator a cycle to drop them.
               state_r  <= IDLE;
               resp_a_r <= 1'b0;
               resp_b_r <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               resp_a_r    <= 1'b0;
               resp_b_r    <= 1'b0;
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
            end
         endcase
      end
   end

   assign rdata_a         = rdata_a_r;
   assign resp_a          = resp_a_r;
   assign rdata_b         = rdata_b_r;
   assign resp_b          = resp_b_r;
   assign mem_read        = mem_read_r;
   assign mem_write       = mem_write_r;
   assign mem_address     = mem_address_r;
   assign mem_wdata       = mem_wdata_r;
   assign mem_byte_enable = mem_byte_enable_r;

endmodule

// File: tb/tb_mem_port_responder.sv
// Self-checking bench for mem_port_responder (default parameters, B_PRIORITY=1).
// Instruction-buffer expectations follow MEM_PORT_IBUF_EN when it is defined.
module tb_mem_port_responder;

   typedef enum logic [1:0] {K_AR, K_BR, K_BW, K_BRW} kind_e;

   typedef struct {
      kind_e       kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      int          k;
      logic [31:0] exp_data;
      logic [31:0] exp_maddr;
      logic [3:0]  exp_be;
      bit          hit;
   } txn_t;

   typedef struct {
      bit          port;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } log_t;

`ifdef MEM_PORT_IBUF_EN
   localparam bit IBUF_C = 1'b1;
`else
   localparam bit IBUF_C = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        read_a;
   logic [31:0] address_a;
   logic [31:0] rdata_a;
   logic        resp_a;
   logic        read_b;
   logic        write;
   logic [3:0]  wmask;
   logic [31:0] address_b;
   logic [31:0] wdata;
   logic [31:0] rdata_b;
   logic        resp_b;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   int          checks = 0;
   int          failures = 0;
   int          k_cfg = 0;
   int          strobe_cyc = 0;
   bit          auto_en = 1'b1;
   logic [31:0] model_a = 32'h0;
   logic [31:0] model_b = 32'h0;
   logic [31:0] backing [logic [31:0]];
   exp_t        sb [$];
   log_t        mem_log [$];
   txn_t        tbl [8];
   txn_t        ib [4];

   mem_port_responder dut (
      .clk             (clk),
      .rst             (rst),
      .read_a          (read_a),
      .address_a       (address_a),
      .rdata_a         (rdata_a),
      .resp_a          (resp_a),
      .read_b          (read_b),
      .write           (write),
      .wmask           (wmask),
      .address_b       (address_b),
      .wdata           (wdata),
      .rdata_b         (rdata_b),
      .resp_b          (resp_b),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Backing memory: answers a strobe after k_cfg extra cycles, merges writes by byte enable.
   initial begin
      int   wait_cnt;
      log_t e;
      logic [31:0] cur;
      wait_cnt  = 0;
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (!auto_en) begin
            wait_cnt = 0;
         end else if (mem_resp) begin
            mem_resp = 1'b0;
            wait_cnt = 0;
         end else if (mem_read || mem_write) begin
            if (wait_cnt >= k_cfg) begin
               mem_resp = 1'b1;
               e.wr    = mem_write;
               e.addr  = mem_address;
               e.wdata = mem_wdata;
               e.be    = mem_byte_enable;
               mem_log.push_back(e);
               cur = backing.exists(mem_address) ? backing[mem_address] : 32'h0;
               if (mem_write) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_byte_enable[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                  backing[mem_address] = cur;
               end else begin
                  mem_rdata = cur;
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Monitor: strobe cycle count, exclusivity, pulse width and scoreboard compare.
   initial begin
      bit   prev_a;
      bit   prev_b;
      exp_t x;
      prev_a = 1'b0;
      prev_b = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_read || mem_write) strobe_cyc++;
         if (mem_read && mem_write) begin
            checks++;
            failures++;
            $display("FAIL strobe_excl: mem_read and mem_write both high");
         end
         if ((resp_a && prev_a) || (resp_b && prev_b)) begin
            checks++;
            failures++;
            $display("FAIL resp_width: resp held longer than one cycle");
         end
         if (resp_a || resp_b) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: resp_a=%0d resp_b=%0d with nothing pending", resp_a, resp_b);
            end else begin
               x = sb.pop_front();
               chk("sb_port", {30'h0, resp_b, resp_a}, x.port ? 32'h2 : 32'h1);
               chk("sb_data", resp_b ? rdata_b : rdata_a, x.data);
            end
         end
         prev_a = resp_a;
         prev_b = resp_b;
      end
   end

   task automatic drive(input txn_t t);
      k_cfg = t.k;
      case (t.kind)
         K_AR: begin
            read_a    = 1'b1;
            address_a = t.addr;
            sb.push_back('{1'b0, t.exp_data});
         end
         K_BR: begin
            read_b    = 1'b1;
            address_b = t.addr;
            sb.push_back('{1'b1, t.exp_data});
         end
         default: begin
            write     = 1'b1;
            read_b    = (t.kind == K_BRW);
            address_b = t.addr;
            wdata     = t.wdata;
            wmask     = t.wmask;
            sb.push_back('{1'b1, model_b});
         end
      endcase
   endtask

   task automatic do_txn(input txn_t t, input string nm);
      int   cyc;
      int   log0;
      bit   got;
      log_t e;
      log0       = mem_log.size();
      strobe_cyc = 0;
      drive(t);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (resp_a || resp_b) got = 1'b1;
      end
      read_a = 1'b0;
      read_b = 1'b0;
      write  = 1'b0;
      chk({nm, "_done"}, {31'h0, got}, 32'h1);
      // Request cycle counts as the first: normal 3+k, buffer hit 2.
      chk({nm, "_lat"}, 32'(cyc + 1), t.hit ? 32'd2 : 32'(3 + t.k));
      chk({nm, "_strobes"}, 32'(strobe_cyc), t.hit ? 32'd0 : 32'(t.k + 1));
      chk({nm, "_nacc"}, 32'(mem_log.size() - log0), t.hit ? 32'd0 : 32'd1);
      if (!t.hit && mem_log.size() > log0) begin
         e = mem_log[mem_log.size() - 1];
         chk({nm, "_op"}, {31'h0, e.wr}, (t.kind == K_BW || t.kind == K_BRW) ? 32'h1 : 32'h0);
         chk({nm, "_maddr"}, e.addr, t.exp_maddr);
         chk({nm, "_be"}, {28'h0, e.be}, {28'h0, t.exp_be});
         if (e.wr) chk({nm, "_wdata"}, e.wdata, t.wdata);
      end
      if (t.kind == K_AR) model_a = t.exp_data;
      if (t.kind == K_BR) model_b = t.exp_data;
      chk({nm, "_hold_a"}, rdata_a, model_a);
      chk({nm, "_hold_b"}, rdata_b, model_b);
      @(negedge clk);
   endtask

   initial begin
      int cyc;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      exp_t dummy;
      backing[32'h60]  = 32'h00000013;
      backing[32'h64]  = 32'hA5A50064;
      backing[32'h68]  = 32'hA5A50068;
      backing[32'h80]  = 32'h0BADF00D;
      backing[32'h100] = 32'h11223344;
      backing[32'h104] = 32'h55667788;

      //          kind   addr        wdata         mask  k  exp_data       maddr        be     hit
      tbl[0] = '{K_AR,  32'h60,  32'h0,        4'h0, 2, 32'h00000013, 32'h60,  4'hF, 1'b0};
      tbl[1] = '{K_BR,  32'h103, 32'h0,        4'h0, 0, 32'h11223344, 32'h100, 4'hF, 1'b0};
      tbl[2] = '{K_BW,  32'h100, 32'hDEADBEEF, 4'h3, 1, 32'h0,        32'h100, 4'h3, 1'b0};
      tbl[3] = '{K_BR,  32'h102, 32'h0,        4'h0, 0, 32'h1122BEEF, 32'h100, 4'hF, 1'b0};
      tbl[4] = '{K_BW,  32'h104, 32'h99999999, 4'h0, 0, 32'h0,        32'h104, 4'h0, 1'b0};
      tbl[5] = '{K_BRW, 32'h200, 32'hCAFEF00D, 4'hF, 0, 32'h0,        32'h200, 4'hF, 1'b0};
      tbl[6] = '{K_BR,  32'h200, 32'h0,        4'h0, 0, 32'hCAFEF00D, 32'h200, 4'hF, 1'b0};
      tbl[7] = '{K_AR,  32'h6A,  32'h0,        4'h0, 3, 32'hA5A50068, 32'h68,  4'hF, 1'b0};

      ib[0] = '{K_AR,  32'h80, 32'h0,        4'h0, 1, 32'h0BADF00D, 32'h80, 4'hF, 1'b0};
      ib[1] = '{K_AR,  32'h82, 32'h0,        4'h0, 1, 32'h0BADF00D, 32'h80, 4'hF, IBUF_C};
      ib[2] = '{K_BW,  32'h80, 32'h12345678, 4'hF, 0, 32'h0,        32'h80, 4'hF, 1'b0};
      ib[3] = '{K_AR,  32'h80, 32'h0,        4'h0, 0, 32'h12345678, 32'h80, 4'hF, 1'b0};

      rst = 1'b1; read_a = 1'b0; read_b = 1'b0; write = 1'b0;
      address_a = 32'h0; address_b = 32'h0; wdata = 32'h0; wmask = 4'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_resp", {30'h0, resp_b, resp_a}, 32'h0);
      chk("rst_strobes", {30'h0, mem_write, mem_read}, 32'h0);
      chk("rst_maddr", mem_address, 32'h0);
      chk("rst_mwdata", mem_wdata, 32'h0);
      chk("rst_be", {28'h0, mem_byte_enable}, 32'h0);
      chk("rst_rdata_a", rdata_a, 32'h0);
      chk("rst_rdata_b", rdata_b, 32'h0);

      for (int i = 0; i < 8; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

      // Simultaneous A read and B write: B wins, then A is served.
      begin
         int log0;
         log0 = mem_log.size();
         k_cfg = 0;
         read_a = 1'b1; address_a = 32'h64;
         write = 1'b1; address_b = 32'h100; wdata = 32'hDEADBEEF; wmask = 4'h3;
         sb.push_back('{1'b1, model_b});
         sb.push_back('{1'b0, 32'hA5A50064});
         cyc = 0;
         while (!resp_b && cyc < 40) begin @(negedge clk); cyc++; end
         write = 1'b0;
         chk("sim_resp_b_first", {30'h0, resp_b, resp_a}, 32'h2);
         cyc = 0;
         while (!resp_a && cyc < 40) begin @(negedge clk); cyc++; end
         read_a = 1'b0;
         chk("sim_resp_a", {31'h0, resp_a}, 32'h1);
         model_a = 32'hA5A50064;
         chk("sim_nacc", 32'(mem_log.size() - log0), 32'd2);
         if (mem_log.size() >= log0 + 2) begin
            chk("sim_first_wr", {31'h0, mem_log[log0].wr}, 32'h1);
            chk("sim_first_addr", mem_log[log0].addr, 32'h100);
            chk("sim_first_be", {28'h0, mem_log[log0].be}, 32'h3);
            chk("sim_second_wr", {31'h0, mem_log[log0+1].wr}, 32'h0);
            chk("sim_second_addr", mem_log[log0+1].addr, 32'h64);
         end
         chk("sim_rdata_b", rdata_b, model_b);
         @(negedge clk);
      end

      for (int i = 0; i < 4; i++) do_txn(ib[i], $sformatf("ibuf%0d", i));

      // Reset during SERVE_A, then a stale mem_resp arrives in IDLE.
      auto_en = 1'b0;
      read_a = 1'b1; address_a = 32'h40;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_strobe", {31'h0, mem_read}, 32'h1);
      rst = 1'b1; read_a = 1'b0;
      @(negedge clk);
      chk("rst_mid_strobes_low", {30'h0, mem_write, mem_read}, 32'h0);
      chk("rst_mid_rdata_a", rdata_a, 32'h0);
      rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      mem_resp = 1'b0;
      chk("late_resp_ignored", {29'h0, mem_read, resp_b, resp_a}, 32'h0);
      @(negedge clk);
      chk("late_resp_idle", {29'h0, mem_read, resp_b, resp_a}, 32'h0);
      chk("late_rdata_a", rdata_a, 32'h0);
      chk("late_rdata_b", rdata_b, 32'h0);
      model_a = 32'h0;
      model_b = 32'h0;
      auto_en = 1'b1;

      // Reset also empties the instruction buffer: this read goes to memory.
      do_txn('{K_AR, 32'h80, 32'h0, 4'h0, 0, 32'h12345678, 32'h80, 4'hF, 1'b0}, "post_rst");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      while (sb.size() > 0) dummy = sb.pop_front();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
